// File: rtl/branch_event_queue.sv
// branch_event_queue: FIFO of resolved branch events (PC, outcome) feeding
// the global predictor. First-word-fall-through head, registered-only
// outputs, occupancy level and a free-running delivered-event counter.
module branch_event_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             in_taken,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PC_W-1:0]  out_pc,
    output logic             out_taken,
    input  logic             out_ready,
    output logic [LVL_W-1:0] level,
    output logic [31:0]      event_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [31:0]      count_q, count_d;
    logic [PC_W:0]    mem_q [DEPTH];
    logic [PC_W:0]    mem_d [DEPTH];
    logic             push;
    logic             pop;

    // Handshakes; a flush discards any transfer in the same cycle
    always_comb begin
        push = in_valid && in_ready && !flush;
        pop  = out_valid && out_ready && !flush;
    end

    // Outputs come from registered state only
    always_comb begin
        in_ready    = (level_q != LVL_W'(DEPTH));
        out_valid   = (level_q != '0);
        out_pc      = mem_q[head_q][PC_W-1:0];
        out_taken   = mem_q[head_q][PC_W];
        level       = level_q;
        event_count = count_q;
    end

    // Pointer, occupancy and delivered-count next state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d  = head_q + PTR_W'(1);
                count_d = count_q + 32'd1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Storage next state: only the tail slot changes on a push
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (push && (tail_q == PTR_W'(i))) begin
                mem_d[i] = {in_taken, in_pc};
            end
        end
    end

    // Control state registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    // Storage registers, cleared on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_branch_event_queue.sv
// Testbench for branch_event_queue: directed steps plus random traffic,
// checked against a queue-based reference model.
module tb_branch_event_queue;

    localparam int DEPTH = 8;
    localparam int PC_W  = 8;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic [PC_W-1:0]  in_pc;
    logic             in_taken;
    logic             in_ready;
    logic             out_valid;
    logic [PC_W-1:0]  out_pc;
    logic             out_taken;
    logic             out_ready;
    logic [LVL_W-1:0] level;
    logic [31:0]      event_count;

    branch_event_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_taken    (in_taken),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_taken   (out_taken),
        .out_ready   (out_ready),
        .level       (level),
        .event_count (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of {taken, pc} plus a delivered counter
    logic [PC_W:0] mq[$];
    logic [31:0]   mcnt;
    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("level", 32'(level), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", 32'(out_pc), 32'(mq[0][PC_W-1:0]));
            chk("out_taken", 32'(out_taken), 32'(mq[0][PC_W]));
        end
        chk("event_count", event_count, mcnt);
    endtask

    // One clock cycle: drive inputs, advance model at the edge, compare after
    task automatic cyc(input logic v, input logic [PC_W-1:0] pc, input logic t,
                       input logic rdy, input logic fl);
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_pc     = pc;
        in_taken  = t;
        out_ready = rdy;
        flush     = fl;
        do_push = v && (mq.size() < DEPTH);
        do_pop  = rdy && (mq.size() > 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                mcnt = mcnt + 32'd1;
            end
            if (do_push) mq.push_back({t, pc});
        end
        #1;
        $display("cyc v=%0b pc=%h t=%0b rdy=%0b fl=%0b -> level=%0d out_valid=%0b out_pc=%h cnt=%0d",
                 v, pc, t, rdy, fl, level, out_valid, out_pc, event_count);
        compare_all();
    endtask

    task automatic push_rand(input logic rdy);
        cyc(1'b1, PC_W'($urandom), 1'($urandom), rdy, 1'b0);
    endtask

    logic [31:0] cnt_save;

    initial begin
        checks    = 0;
        errors    = 0;
        mcnt      = 32'd0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_taken  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1;

        // Three pushes, then drain in order
        cyc(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
        chk("three_level", 32'(level), 32'd3);
        chk("first_pc", 32'(out_pc), 32'h10);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("three_count", event_count, 32'd3);
        chk("three_empty", 32'(level), 32'd0);

        // Fill, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) push_rand(1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Full with push and pop together: pop only, push lands next cycle
        for (int i = 0; i < DEPTH; i++) push_rand(1'b0);
        push_rand(1'b1);
        chk("full_pop_only", 32'(level), 32'd7);
        push_rand(1'b0);
        chk("refill", 32'(level), 32'd8);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Continuous stream of 20 events
        cnt_save = event_count;
        for (int i = 0; i < 20; i++) begin
            push_rand(1'b1);
            chk("stream_level", 32'(level), 32'd1);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("stream_count", event_count - cnt_save, 32'd20);

        // Flush with simultaneous push and pop at level 5
        for (int i = 0; i < 5; i++) push_rand(1'b0);
        cnt_save = event_count;
        cyc(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_count", event_count, cnt_save);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), PC_W'($urandom), 1'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset mid-cycle with level 4
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) push_rand(1'b0);
        chk("pre_reset_level", 32'(level), 32'd4);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #3;
        reset_n = 1'b0;
        mq.delete();
        mcnt = 32'd0;
        #1;
        chk("async_level", 32'(level), 32'd0);
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_ready", 32'(in_ready), 32'd1);
        chk("async_count", event_count, 32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all();

        // Post-reset sanity
        for (int i = 0; i < 3; i++) push_rand(1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
